// File: rtl/ddr_pkg.sv
// Shared definitions for MCB user-port controllers: command encodings,
// scheduler state encoding and the MCB data FIFO depth.
package ddr_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int MCB_FIFO_DEPTH = 64;

    // CALIB must encode as zero so state_dbg reads 0 out of reset.
    typedef enum logic [1:0] {
        CALIB = 2'd0,
        IDLE  = 2'd1,
        CMD   = 2'd2,
        ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for slow asynchronous level flags (e.g. MCB
// calibration done). The output is low until two clean samples are taken.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_reg;
    logic [W-1:0] sync_reg;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/ddr_frame_scheduler.sv
// Single MCB user-port scheduler shared between the pixel writer (back
// buffer) and the display reader (front buffer). Issues one burst command
// per three cycles, keeps per-frame write/read pointers, and swaps buffers
// only at a display vsync that follows a completed writer frame.
module ddr_frame_scheduler
    import ddr_pkg::*;
#(
    parameter int FRAME_BYTES = 282240,
    parameter int BUF0_BASE   = 0,
    parameter int BUF1_BASE   = 282240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_calib_done,
    input  logic        wr_req,
    input  logic [6:0]  wr_len,
    output logic        wr_done,
    input  logic        frame_done,
    input  logic        rd_req,
    input  logic [6:0]  rd_len,
    output logic        rd_done,
    input  logic        frame_start,
    input  logic        cmd_full,
    input  logic [6:0]  wr_count,
    input  logic [6:0]  rd_count,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    output logic        memory_frame,
    output logic        overflow,
    output logic [3:0]  state_dbg
);

    localparam logic [29:0] FRAME_LIMIT = 30'(FRAME_BYTES);
    localparam logic [29:0] BUF0_ADDR   = 30'(BUF0_BASE);
    localparam logic [29:0] BUF1_ADDR   = 30'(BUF1_BASE);
    localparam logic [7:0]  FIFO_LIMIT  = 8'(MCB_FIFO_DEPTH);

    state_t      state_reg;
    logic [29:0] wr_ptr_reg;
    logic [29:0] rd_ptr_reg;
    logic        swap_pend_reg;
    logic        vsync_pend_reg;
    logic        last_rd_reg;     // 0: last served was a write (reset value)
    logic        is_rd_reg;       // type of the command in flight
    logic [6:0]  len_reg;         // length of the command in flight

    logic        calib_sync;
    logic        wr_elig;
    logic        rd_elig;
    logic        pick_rd;
    logic [7:0]  rd_fill;
    logic [29:0] back_base;
    logic [29:0] front_base;
    logic [29:0] wr_addr;
    logic [29:0] rd_addr;
    logic [6:0]  sel_len;
    logic [6:0]  sel_len_m1;
    logic [29:0] sel_ptr;
    logic [29:0] ptr_sum;
    logic        ptr_wrap;
    logic        vsync_take;

    sync2 #(.W(1)) u_calib_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mem_calib_done),
        .q     (calib_sync)
    );

    // Request eligibility: a write needs its data already in the write FIFO,
    // a read needs room for the whole burst in the read FIFO.
    assign rd_fill = {1'b0, rd_count} + {1'b0, rd_len};
    assign wr_elig = wr_req && !cmd_full && (wr_count >= wr_len);
    assign rd_elig = rd_req && !cmd_full && (rd_fill <= FIFO_LIMIT);

    // Round-robin only matters under contention: then serve the type that
    // did not go last.
    assign pick_rd = rd_elig && (!wr_elig || !last_rd_reg);

    // The writer always fills the buffer the display is not showing.
    assign back_base  = memory_frame ? BUF0_ADDR : BUF1_ADDR;
    assign front_base = memory_frame ? BUF1_ADDR : BUF0_ADDR;
    assign wr_addr    = back_base + wr_ptr_reg;
    assign rd_addr    = front_base + rd_ptr_reg;
    assign sel_len    = pick_rd ? rd_len : wr_len;
    assign sel_len_m1 = sel_len - 7'd1;

    // Pointer advance for the command in flight, wrapping at the frame end.
    assign sel_ptr  = is_rd_reg ? rd_ptr_reg : wr_ptr_reg;
    assign ptr_sum  = sel_ptr + {21'd0, len_reg, 2'b00};
    assign ptr_wrap = (ptr_sum >= FRAME_LIMIT);

    assign vsync_take = (state_reg == IDLE) && vsync_pend_reg;
    assign state_dbg  = {2'b00, state_reg};

    // Frame events are latched in any state; a fresh pulse wins over the
    // clear so an event arriving in the consuming cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_pend_reg  <= 1'b0;
            vsync_pend_reg <= 1'b0;
        end else begin
            if (frame_done) begin
                swap_pend_reg <= 1'b1;
            end else if (vsync_take) begin
                swap_pend_reg <= 1'b0;
            end
            if (frame_start) begin
                vsync_pend_reg <= 1'b1;
            end else if (vsync_take) begin
                vsync_pend_reg <= 1'b0;
            end
        end
    end

    // Main sequencer: calibration wait, arbitration, command strobe, ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= CALIB;
            cmd_en        <= 1'b0;
            cmd_instr     <= 3'b000;
            cmd_bl        <= 6'd0;
            cmd_byte_addr <= 30'd0;
            wr_done       <= 1'b0;
            rd_done       <= 1'b0;
            memory_frame  <= 1'b0;
            overflow      <= 1'b0;
            wr_ptr_reg    <= 30'd0;
            rd_ptr_reg    <= 30'd0;
            last_rd_reg   <= 1'b0;
            is_rd_reg     <= 1'b0;
            len_reg       <= 7'd0;
        end else begin
            cmd_en  <= 1'b0;
            wr_done <= 1'b0;
            rd_done <= 1'b0;
            case (state_reg)
                CALIB: begin
                    if (calib_sync) begin
                        state_reg <= IDLE;
                    end
                end
                IDLE: begin
                    if (vsync_pend_reg) begin
                        if (swap_pend_reg) begin
                            memory_frame <= ~memory_frame;
                            wr_ptr_reg   <= 30'd0;
                        end
                        rd_ptr_reg <= 30'd0;
                    end else if (wr_elig || rd_elig) begin
                        is_rd_reg     <= pick_rd;
                        last_rd_reg   <= pick_rd;
                        len_reg       <= sel_len;
                        cmd_instr     <= pick_rd ? CMD_READ : CMD_WRITE;
                        cmd_bl        <= sel_len_m1[5:0];
                        cmd_byte_addr <= pick_rd ? rd_addr : wr_addr;
                        cmd_en        <= 1'b1;
                        state_reg     <= CMD;
                    end
                end
                CMD: begin
                    wr_done   <= !is_rd_reg;
                    rd_done   <= is_rd_reg;
                    state_reg <= ACK;
                end
                ACK: begin
                    if (is_rd_reg) begin
                        rd_ptr_reg <= ptr_wrap ? 30'd0 : ptr_sum;
                    end else begin
                        wr_ptr_reg <= ptr_wrap ? 30'd0 : ptr_sum;
                    end
                    if (ptr_wrap) begin
                        overflow <= 1'b1;
                    end
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= CALIB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_frame_scheduler.sv
// Scoreboard bench for ddr_frame_scheduler. Stimulus tasks update a
// transaction-level model of the frame store and push the expected MCB
// commands; an independent monitor pops and compares on every cmd_en.
module tb_ddr_frame_scheduler;

    localparam int FB = 282240;
    localparam int B0 = 0;
    localparam int B1 = 282240;

    logic        clk;
    logic        rst_n;
    logic        mem_calib_done;
    logic        wr_req;
    logic [6:0]  wr_len;
    logic        wr_done;
    logic        frame_done;
    logic        rd_req;
    logic [6:0]  rd_len;
    logic        rd_done;
    logic        frame_start;
    logic        cmd_full;
    logic [6:0]  wr_count;
    logic [6:0]  rd_count;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        memory_frame;
    logic        overflow;
    logic [3:0]  state_dbg;

    ddr_frame_scheduler #(
        .FRAME_BYTES (FB),
        .BUF0_BASE   (B0),
        .BUF1_BASE   (B1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_calib_done (mem_calib_done),
        .wr_req         (wr_req),
        .wr_len         (wr_len),
        .wr_done        (wr_done),
        .frame_done     (frame_done),
        .rd_req         (rd_req),
        .rd_len         (rd_len),
        .rd_done        (rd_done),
        .frame_start    (frame_start),
        .cmd_full       (cmd_full),
        .wr_count       (wr_count),
        .rd_count       (rd_count),
        .cmd_en         (cmd_en),
        .cmd_instr      (cmd_instr),
        .cmd_bl         (cmd_bl),
        .cmd_byte_addr  (cmd_byte_addr),
        .memory_frame   (memory_frame),
        .overflow       (overflow),
        .state_dbg      (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  instr;
        logic [5:0]  bl;
        logic [29:0] addr;
    } cmd_t;

    cmd_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model of the frame store.
    int unsigned m_wr_ptr = 0;
    int unsigned m_rd_ptr = 0;
    bit          m_frame = 0;
    bit          m_swap_pend = 0;
    bit          m_overflow = 0;
    bit          m_last_rd = 0;

    // Monitor bookkeeping.
    int   cyc = 0;
    int   last_cmd_cyc = -100;
    int   last_gap = 0;
    int   cmd_total = 0;
    bit   done_due = 0;
    bit   done_is_wr = 0;
    cmd_t mon_c;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One burst served: compute its address from the buffer rules and
    // advance the matching pointer by len*4 bytes, wrapping at the frame end.
    function automatic void model_issue(input bit rd, input int len);
        cmd_t c;
        int unsigned base;
        if (rd) begin
            base    = m_frame ? B1 : B0;
            c.instr = 3'b001;
            c.addr  = 30'(base + m_rd_ptr);
            m_rd_ptr += len * 4;
            if (m_rd_ptr >= FB) begin
                m_rd_ptr   = 0;
                m_overflow = 1;
            end
        end else begin
            base    = m_frame ? B0 : B1;
            c.instr = 3'b000;
            c.addr  = 30'(base + m_wr_ptr);
            m_wr_ptr += len * 4;
            if (m_wr_ptr >= FB) begin
                m_wr_ptr   = 0;
                m_overflow = 1;
            end
        end
        c.bl = 6'(len - 1);
        exp_q.push_back(c);
        m_last_rd = rd;
    endfunction

    function automatic void model_frame(input bit fd, input bit fs);
        if (fd) m_swap_pend = 1;
        if (fs) begin
            if (m_swap_pend) begin
                m_frame     = !m_frame;
                m_wr_ptr    = 0;
                m_swap_pend = 0;
            end
            m_rd_ptr = 0;
        end
    endfunction

    // Monitor: compares every command against the scoreboard and checks the
    // done pulse lands exactly one cycle after cmd_en.
    always @(negedge clk) begin
        if (!rst_n) begin
            done_due = 0;
        end else begin
            cyc++;
            if (done_due) begin
                chk("wr_done_pulse", wr_done, done_is_wr);
                chk("rd_done_pulse", rd_done, !done_is_wr);
                done_due = 0;
            end else begin
                chk("no_done", {wr_done, rd_done}, 2'b00);
            end
            if (cmd_en) begin
                cmd_total++;
                last_gap     = cyc - last_cmd_cyc;
                last_cmd_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", {cmd_instr, cmd_byte_addr}, 64'hDEAD);
                end else begin
                    mon_c = exp_q.pop_front();
                    chk("cmd_instr", cmd_instr, mon_c.instr);
                    chk("cmd_bl", cmd_bl, mon_c.bl);
                    chk("cmd_addr", cmd_byte_addr, mon_c.addr);
                    $display("cmd %0d instr=%0d bl=%0d addr=%0d", cmd_total, cmd_instr, cmd_bl, cmd_byte_addr);
                end
                done_due   = 1;
                done_is_wr = (cmd_instr == 3'b000);
            end
        end
    end

    // Wait until every raised request has seen its done pulse; each
    // requester drops its req in the done cycle. Ends in the following cycle.
    task automatic wait_dones(input bit w, input bit r, input int full_cycles);
        int n;
        bit wd;
        bit rdn;
        n   = 0;
        wd  = !w;
        rdn = !r;
        while (1) begin
            if (n >= full_cycles) cmd_full = 1'b0;
            if (wr_done && w) begin wd = 1; wr_req = 1'b0; end
            if (rd_done && r) begin rdn = 1; rd_req = 1'b0; end
            if (wd && rdn) break;
            if (n >= 400) break;
            tick();
            n++;
        end
        chk("req_served", {wd, rdn}, 2'b11);
        wr_req   = 1'b0;
        rd_req   = 1'b0;
        cmd_full = 1'b0;
        tick();
    endtask

    task automatic do_req(input bit w, input bit r, input int wl, input int rl, input int full_cycles);
        wr_len   = 7'(wl);
        wr_count = 7'($urandom_range(64, wl));
        rd_len   = 7'(rl);
        rd_count = 7'($urandom_range(64 - rl, 0));
        if (w && r) begin
            if (m_last_rd) begin
                model_issue(0, wl);
                model_issue(1, rl);
            end else begin
                model_issue(1, rl);
                model_issue(0, wl);
            end
        end else if (w) begin
            model_issue(0, wl);
        end else begin
            model_issue(1, rl);
        end
        cmd_full = (full_cycles > 0);
        wr_req   = w;
        rd_req   = r;
        wait_dones(w, r, full_cycles);
        chk("overflow", overflow, m_overflow);
        chk("memory_frame", memory_frame, m_frame);
    endtask

    task automatic frame_ev(input bit fd, input bit fs);
        frame_done  = fd;
        frame_start = fs;
        tick();
        frame_done  = 1'b0;
        frame_start = 1'b0;
        model_frame(fd, fs);
        tick();
        tick();
        chk("frame_sel", memory_frame, m_frame);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int k;
        rst_n = 1'b0; mem_calib_done = 1'b0;
        wr_req = 1'b0; wr_len = 7'd1; frame_done = 1'b0;
        rd_req = 1'b0; rd_len = 7'd1; frame_start = 1'b0;
        cmd_full = 1'b0; wr_count = 7'd0; rd_count = 7'd0;
        tick();
        tick();
        chk("rst_outputs", {cmd_en, wr_done, rd_done, cmd_instr, cmd_bl, memory_frame, overflow, state_dbg}, 0);
        chk("rst_addr", cmd_byte_addr, 0);
        rst_n = 1'b1;

        // Calibration hold with a pending write, then release.
        wr_len = 7'd64; wr_count = 7'd64; wr_req = 1'b1;
        repeat (100) tick();
        chk("calib_hold_state", state_dbg, 0);
        model_issue(0, 64);
        mem_calib_done = 1'b1;
        tick();
        tick();
        chk("calib_not_yet", state_dbg, 0);
        tick();
        chk("calib_idle", state_dbg, 1);
        wait_dones(1, 0, 0);
        do_req(1, 0, 64, 1, 0);

        // Contention twice: read, write, read, write; three cycles apart.
        do_req(1, 1, 10, 20, 0);
        chk("contention_gap", last_gap, 3);
        do_req(1, 1, 5, 7, 2);
        chk("contention_gap2", last_gap, 3);

        // Read gating on read-FIFO room.
        n = cmd_total;
        rd_len = 7'd32; rd_count = 7'd40; rd_req = 1'b1;
        repeat (20) tick();
        chk("gated_read", cmd_total, n);
        model_issue(1, 32);
        rd_count = 7'd32;
        wait_dones(0, 1, 0);

        // Writer finishes a frame; vsync lands while a write is in CMD.
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        model_frame(1, 0);
        repeat (50) tick();
        wr_len = 7'd16; wr_count = 7'd64;
        model_issue(0, 16);
        wr_req = 1'b1;
        n = 0;
        while (!cmd_en && n < 50) begin tick(); n++; end
        chk("swap_cmd_seen", cmd_en, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        model_frame(0, 1);
        wait_dones(1, 0, 0);
        tick();
        chk("swap_toggled", memory_frame, 1);
        do_req(1, 0, 8, 1, 0);
        do_req(0, 1, 1, 8, 0);
        frame_ev(0, 1);
        do_req(1, 0, 4, 1, 0);
        do_req(0, 1, 1, 4, 0);
        frame_ev(1, 1);
        do_req(1, 1, 3, 3, 0);

        // Fill the back buffer until the write pointer wraps.
        n = 0;
        while (!m_overflow && n < 2000) begin
            do_req(1, 0, 64, 1, 0);
            n++;
        end
        do_req(1, 0, 64, 1, 0);
        chk("overflow_sticky", overflow, 1);

        // Randomised traffic and frame events.
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 6);
            case (k)
                0, 1: do_req(1, 0, $urandom_range(64, 1), 1, $urandom_range(3, 0));
                2, 3: do_req(0, 1, 1, $urandom_range(64, 1), $urandom_range(3, 0));
                4:    do_req(1, 1, $urandom_range(64, 1), $urandom_range(64, 1), $urandom_range(3, 0));
                5:    frame_ev($urandom_range(1, 0), $urandom_range(1, 0));
                default: frame_ev(1, 1);
            endcase
        end
        tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        // Reset in the middle of a burst.
        wr_len = 7'd4; wr_count = 7'd64; wr_req = 1'b1;
        n = 0;
        while (!cmd_en && n < 50) begin tick(); n++; end
        chk("midburst_cmd_seen", cmd_en, 1);
        rst_n = 1'b0;
        #1;
        chk("midburst_cmd_drop", cmd_en, 0);
        chk("midburst_state", state_dbg, 0);
        chk("midburst_regs", {memory_frame, overflow}, 0);
        wr_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("recalib_idle", state_dbg, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
